sobel_edge_combine: RTL and testbench

- Downstream consumer of the vertical and horizontal Sobel convolution stages.
- Takes the two absolute-gradient pixel streams, which arrive with differing latencies, and realigns them through per-stream FIFOs.
- Computes a saturated gradient magnitude, optionally thresholds it to a binary edge map, and drives gray RGB to the display path.
- Keeps a per-frame count of edge pixels for the status readout.

---
 rtl/sobel_edge_combine.sv | 209 ++++++++++++++++++++
 tb/tb_sobel_edge_combine.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_edge_combine.sv
// Realigns |Gx| and |Gy| streams through per-stream FIFOs, forms a saturated magnitude,
// optionally thresholds it to an edge map, and keeps a per-frame edge-pixel count.

module sobel_align_fifo #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 8
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic              o_empty,
    output logic [DATA_W-1:0] o_data,
    output logic              o_drop
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic [AW-1:0]     w_wr_addr;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop     = i_pop && !o_empty && !i_flush;
    // A full FIFO still accepts a sample when its head leaves in the same cycle.
    assign w_push    = i_push && (i_flush || !w_full || w_pop);
    assign w_wr_addr = i_flush ? '0 : r_wr_ptr[AW-1:0];
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];
    assign o_drop    = i_push && w_full && !w_pop && !i_flush;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= {{AW{1'b0}}, i_push};
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (w_push) r_mem[w_wr_addr] <= i_data;
    end
endmodule

module sobel_edge_combine #(
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 22
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [DATA_W-1:0] iGX_DATA,
    input  logic              iGX_DVAL,
    input  logic [DATA_W-1:0] iGY_DATA,
    input  logic              iGY_DVAL,
    input  logic [DATA_W-1:0] iTHRESH,
    input  logic [1:0]        iMODE,
    input  logic              iFRAME_START,
    output logic [DATA_W-1:0] oRed,
    output logic [DATA_W-1:0] oGreen,
    output logic [DATA_W-1:0] oBlue,
    output logic              oDVAL,
    output logic [CNT_W-1:0]  oEDGE_COUNT,
    output logic              oCOUNT_VALID,
    output logic              oOVERFLOW
);
    localparam logic [DATA_W-1:0] PIX_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    logic              w_gx_empty;
    logic              w_gy_empty;
    logic [DATA_W-1:0] w_gx_head;
    logic [DATA_W-1:0] w_gy_head;
    logic              w_gx_drop;
    logic              w_gy_drop;
    logic              w_pop;

    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_gx;
    logic [DATA_W-1:0] r_s1_gy;
    logic [DATA_W-1:0] r_s1_thresh;
    logic [1:0]        r_s1_mode;

    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_sum_sat;
    logic [DATA_W-1:0] w_max;
    logic              w_edge;
    logic [DATA_W-1:0] w_pix;

    logic [DATA_W-1:0] r_pix;
    logic              r_dval;
    logic              r_edge;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_next;
    logic [CNT_W-1:0]  r_edge_count;
    logic              r_count_valid;
    logic              r_overflow;

    // Frame start flushes the FIFOs, so their heads are not popped that cycle.
    assign w_pop = !w_gx_empty && !w_gy_empty && !iFRAME_START;

    sobel_align_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_gx_fifo (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .i_flush (iFRAME_START),
        .i_push  (iGX_DVAL),
        .i_data  (iGX_DATA),
        .i_pop   (w_pop),
        .o_empty (w_gx_empty),
        .o_data  (w_gx_head),
        .o_drop  (w_gx_drop)
    );

    sobel_align_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_gy_fifo (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .i_flush (iFRAME_START),
        .i_push  (iGY_DVAL),
        .i_data  (iGY_DATA),
        .i_pop   (w_pop),
        .o_empty (w_gy_empty),
        .o_data  (w_gy_head),
        .o_drop  (w_gy_drop)
    );

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_s1_valid  <= 1'b0;
            r_s1_gx     <= '0;
            r_s1_gy     <= '0;
            r_s1_thresh <= '0;
            r_s1_mode   <= '0;
        end else begin
            r_s1_valid <= w_pop;
            if (w_pop) begin
                r_s1_gx     <= w_gx_head;
                r_s1_gy     <= w_gy_head;
                r_s1_thresh <= iTHRESH;
                r_s1_mode   <= iMODE;
            end
        end
    end

    assign w_sum     = {1'b0, r_s1_gx} + {1'b0, r_s1_gy};
    assign w_sum_sat = w_sum[DATA_W] ? PIX_MAX : w_sum[DATA_W-1:0];
    assign w_edge    = (w_sum_sat >= r_s1_thresh);
    assign w_max     = (r_s1_gx >= r_s1_gy) ? r_s1_gx : r_s1_gy;

    always_comb begin
        w_pix = w_sum_sat;
        case (r_s1_mode)
            2'd1:    w_pix = w_edge ? PIX_MAX : '0;
            2'd2:    w_pix = w_max;
            default: w_pix = w_sum_sat;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_pix  <= '0;
            r_dval <= 1'b0;
            r_edge <= 1'b0;
        end else begin
            r_dval <= r_s1_valid;
            r_edge <= r_s1_valid && w_edge;
            if (r_s1_valid) r_pix <= w_pix;
        end
    end

    // The pixel on the output this cycle still belongs to the frame being closed.
    assign w_count_next = (r_dval && r_edge && (r_count != CNT_MAX)) ? r_count + 1'b1 : r_count;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_count       <= '0;
            r_edge_count  <= '0;
            r_count_valid <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_count_valid <= iFRAME_START;
            if (iFRAME_START) begin
                r_edge_count <= w_count_next;
                r_count      <= '0;
                r_overflow   <= 1'b0;
            end else begin
                r_count <= w_count_next;
                if (w_gx_drop || w_gy_drop) r_overflow <= 1'b1;
            end
        end
    end

    assign oRed         = r_pix;
    assign oGreen       = r_pix;
    assign oBlue        = r_pix;
    assign oDVAL        = r_dval;
    assign oEDGE_COUNT  = r_edge_count;
    assign oCOUNT_VALID = r_count_valid;
    assign oOVERFLOW    = r_overflow;
endmodule

// File: tb/tb_sobel_edge_combine.sv
// Random and directed stimulus for sobel_edge_combine, checked against a queue-based
// reference of the realign / magnitude / count behaviour.

module tb_sobel_edge_combine;
    localparam int DW    = 12;
    localparam int DEPTH = 8;
    localparam int CW    = 22;
    localparam int PMAX  = (1 << DW) - 1;
    localparam int CMAX  = (1 << CW) - 1;

    logic          iCLK = 1'b0;
    logic          iRST = 1'b0;
    logic [DW-1:0] iGX_DATA = '0;
    logic          iGX_DVAL = 1'b0;
    logic [DW-1:0] iGY_DATA = '0;
    logic          iGY_DVAL = 1'b0;
    logic [DW-1:0] iTHRESH = '0;
    logic [1:0]    iMODE = '0;
    logic          iFRAME_START = 1'b0;
    logic [DW-1:0] oRed;
    logic [DW-1:0] oGreen;
    logic [DW-1:0] oBlue;
    logic          oDVAL;
    logic [CW-1:0] oEDGE_COUNT;
    logic          oCOUNT_VALID;
    logic          oOVERFLOW;

    sobel_edge_combine #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .iCLK         (iCLK),
        .iRST         (iRST),
        .iGX_DATA     (iGX_DATA),
        .iGX_DVAL     (iGX_DVAL),
        .iGY_DATA     (iGY_DATA),
        .iGY_DVAL     (iGY_DVAL),
        .iTHRESH      (iTHRESH),
        .iMODE        (iMODE),
        .iFRAME_START (iFRAME_START),
        .oRed         (oRed),
        .oGreen       (oGreen),
        .oBlue        (oBlue),
        .oDVAL        (oDVAL),
        .oEDGE_COUNT  (oEDGE_COUNT),
        .oCOUNT_VALID (oCOUNT_VALID),
        .oOVERFLOW    (oOVERFLOW)
    );

    always #5 iCLK = ~iCLK;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, exp_v, $time);
        end
    endtask

    // Reference state: queues for the alignment buffers, plain values for the rest.
    int m_qx[$];
    int m_qy[$];
    bit m_s1v;
    int m_s1gx, m_s1gy, m_s1th, m_s1md;
    bit m_dv, m_edge, m_cv, m_ovf;
    int m_pix, m_cnt, m_ecnt;

    task automatic model_clear();
        m_qx.delete(); m_qy.delete();
        m_s1v = 0; m_s1gx = 0; m_s1gy = 0; m_s1th = 0; m_s1md = 0;
        m_dv = 0; m_edge = 0; m_cv = 0; m_ovf = 0;
        m_pix = 0; m_cnt = 0; m_ecnt = 0;
    endtask

    task automatic model_update();
        bit pop, e;
        int s, v, cnt_n;
        if (!iRST) begin
            model_clear();
            return;
        end
        pop = (m_qx.size() > 0) && (m_qy.size() > 0) && !iFRAME_START;
        cnt_n = (m_dv && m_edge && m_cnt < CMAX) ? m_cnt + 1 : m_cnt;
        m_cv = iFRAME_START;
        if (iFRAME_START) begin
            m_ecnt = cnt_n;
            m_cnt = 0;
        end else begin
            m_cnt = cnt_n;
        end
        if (m_s1v) begin
            s = m_s1gx + m_s1gy;
            if (s > PMAX) s = PMAX;
            e = (s >= m_s1th);
            case (m_s1md)
                1: v = e ? PMAX : 0;
                2: v = (m_s1gx > m_s1gy) ? m_s1gx : m_s1gy;
                default: v = s;
            endcase
            m_dv = 1; m_edge = e; m_pix = v;
        end else begin
            m_dv = 0; m_edge = 0;
        end
        if (pop) begin
            m_s1v = 1; m_s1gx = m_qx[0]; m_s1gy = m_qy[0];
            m_s1th = int'(iTHRESH); m_s1md = int'(iMODE);
        end else begin
            m_s1v = 0;
        end
        if (iFRAME_START) begin
            m_qx.delete(); m_qy.delete();
            m_ovf = 0;
            if (iGX_DVAL) m_qx.push_back(int'(iGX_DATA));
            if (iGY_DVAL) m_qy.push_back(int'(iGY_DATA));
        end else begin
            if (pop) begin
                void'(m_qx.pop_front());
                void'(m_qy.pop_front());
            end
            if (iGX_DVAL) begin
                if (m_qx.size() < DEPTH) m_qx.push_back(int'(iGX_DATA));
                else m_ovf = 1;
            end
            if (iGY_DVAL) begin
                if (m_qy.size() < DEPTH) m_qy.push_back(int'(iGY_DATA));
                else m_ovf = 1;
            end
        end
    endtask

    task automatic step();
        @(posedge iCLK);
        model_update();
        #1;
        check("dval", int'(oDVAL), int'(m_dv));
        check("red", int'(oRed), m_pix);
        check("green", int'(oGreen), m_pix);
        check("blue", int'(oBlue), m_pix);
        check("edge_count", int'(oEDGE_COUNT), m_ecnt);
        check("count_valid", int'(oCOUNT_VALID), int'(m_cv));
        check("overflow", int'(oOVERFLOW), int'(m_ovf));
    endtask

    task automatic idle_inputs();
        iGX_DVAL = 0; iGY_DVAL = 0; iFRAME_START = 0;
        iGX_DATA = '0; iGY_DATA = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        iRST = 0;
        step();
        step();
        check("rst_dval", int'(oDVAL), 0);
        check("rst_red", int'(oRed), 0);
        check("rst_ecnt", int'(oEDGE_COUNT), 0);
        check("rst_ovf", int'(oOVERFLOW), 0);
        check("rst_cv", int'(oCOUNT_VALID), 0);
        iRST = 1;
    endtask

    task automatic run_example(input int mode, input int e0, input int e1, input int e2);
        int gxs[3];
        int gys[3];
        int ev[3];
        gxs[0] = 100; gxs[1] = 200; gxs[2] = 300;
        gys[0] = 50;  gys[1] = 60;  gys[2] = 4000;
        ev[0] = e0; ev[1] = e1; ev[2] = e2;
        do_reset();
        iMODE = 2'(mode);
        iTHRESH = DW'(256);
        for (int c = 0; c < 10; c++) begin
            idle_inputs();
            if (c < 3) begin
                iGX_DVAL = 1; iGX_DATA = DW'(gxs[c]);
            end
            if (c >= 4 && c < 7) begin
                iGY_DVAL = 1; iGY_DATA = DW'(gys[c-4]);
            end
            step();
            if (c >= 6 && c <= 8) begin
                check("ex_dval", int'(oDVAL), 1);
                check("ex_pix", int'(oRed), ev[c-6]);
            end else begin
                check("ex_dval_idle", int'(oDVAL), 0);
            end
        end
    endtask

    initial begin
        model_clear();
        do_reset();

        run_example(0, 150, 260, 4095);
        run_example(1, 0, 4095, 4095);
        run_example(2, 100, 200, 4000);

        // Ten-pixel frame with four pixels at or above threshold.
        do_reset();
        iMODE = 0; iTHRESH = DW'(600);
        iFRAME_START = 1;
        step();
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            iGX_DVAL = 1; iGX_DATA = DW'(i * 100);
            iGY_DVAL = 1; iGY_DATA = DW'(i);
            step();
        end
        idle_inputs();
        repeat (4) step();
        iFRAME_START = 1;
        step();
        check("frame_ecnt", int'(oEDGE_COUNT), 4);
        check("frame_cv", int'(oCOUNT_VALID), 1);
        iFRAME_START = 0;
        step();
        check("frame_cv_pulse", int'(oCOUNT_VALID), 0);
        check("frame_ecnt_hold", int'(oEDGE_COUNT), 4);
        iFRAME_START = 1;
        step();
        check("empty_frame_ecnt", int'(oEDGE_COUNT), 0);
        iFRAME_START = 0;

        // Nine GX samples with GY idle: the ninth is dropped.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            iGX_DVAL = 1; iGX_DATA = DW'(i + 1);
            step();
            if (i == 7) check("ovf_before", int'(oOVERFLOW), 0);
        end
        check("ovf_set", int'(oOVERFLOW), 1);
        idle_inputs();
        repeat (3) step();
        check("ovf_sticky", int'(oOVERFLOW), 1);
        iFRAME_START = 1;
        step();
        check("ovf_cleared", int'(oOVERFLOW), 0);
        iFRAME_START = 0;

        // GX full, then a push in the same cycle as a pop is accepted.
        do_reset();
        iMODE = 2; iTHRESH = DW'(10);
        for (int i = 0; i < 8; i++) begin
            iGX_DVAL = 1; iGX_DATA = DW'(10 + i);
            step();
        end
        idle_inputs();
        iGY_DVAL = 1; iGY_DATA = DW'(1);
        step();
        iGX_DVAL = 1; iGX_DATA = DW'(99);
        iGY_DVAL = 1; iGY_DATA = DW'(2);
        step();
        check("full_pushpop_ovf", int'(oOVERFLOW), 0);
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            iGY_DVAL = 1; iGY_DATA = DW'(3 + i);
            step();
        end
        idle_inputs();
        repeat (4) step();
        check("full_drain_last", int'(oRed), 99);
        check("full_drain_ovf", int'(oOVERFLOW), 0);

        // Frame start in the same cycle as an edge pixel on the output.
        do_reset();
        iMODE = 0; iTHRESH = DW'(100);
        iFRAME_START = 1;
        step();
        iFRAME_START = 0;
        iGX_DVAL = 1; iGX_DATA = DW'(200);
        iGY_DVAL = 1; iGY_DATA = DW'(100);
        step();
        idle_inputs();
        step();
        step();
        check("coinc_dval", int'(oDVAL), 1);
        iFRAME_START = 1;
        step();
        check("coinc_ecnt", int'(oEDGE_COUNT), 1);
        iFRAME_START = 1;
        step();
        check("coinc_restart", int'(oEDGE_COUNT), 0);
        iFRAME_START = 0;

        // Randomized traffic with a mid-stream reset.
        do_reset();
        for (int seg = 0; seg < 12; seg++) begin
            int px, py;
            px = $urandom_range(20, 100);
            py = $urandom_range(20, 100);
            for (int c = 0; c < 250; c++) begin
                if (seg == 6 && c == 100) begin
                    iRST = 0;
                    idle_inputs();
                    step();
                    step();
                    check("mid_rst_dval", int'(oDVAL), 0);
                    check("mid_rst_red", int'(oRed), 0);
                    iRST = 1;
                    iGX_DVAL = 1; iGX_DATA = DW'(7);
                    iGY_DVAL = 1; iGY_DATA = DW'(8);
                    iMODE = 0;
                    step();
                    idle_inputs();
                    step();
                    check("rst_lat_c2", int'(oDVAL), 0);
                    step();
                    check("rst_lat_c3", int'(oDVAL), 1);
                    check("rst_lat_pix", int'(oRed), 15);
                end
                iGX_DVAL = ($urandom_range(0, 99) < px);
                iGY_DVAL = ($urandom_range(0, 99) < py);
                iGX_DATA = DW'(($urandom_range(0, 3) == 0) ? $urandom_range(3000, PMAX) : $urandom_range(0, 2000));
                iGY_DATA = DW'(($urandom_range(0, 3) == 0) ? $urandom_range(3000, PMAX) : $urandom_range(0, 2000));
                if ($urandom_range(0, 15) == 0) iMODE = 2'($urandom_range(0, 3));
                iTHRESH = DW'(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(0, PMAX));
                iFRAME_START = ($urandom_range(0, 149) == 0);
                step();
            end
        end
        idle_inputs();
        repeat (5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
